// File: rtl/mem_read_arbiter_if.sv
// mem_read_arbiter_if
// Purpose : bundles the two client read ports, the bit8mem read port and the
//           busy flag of mem_read_arbiter into one interface.
// Modports:
//   master - the arbiter: takes client requests and memory data, drives
//            client responses, memory address/readE and busy.
//   slave  - the environment: clients and memory.
// Optional: MEMARB_STATS_EN adds the 16-bit grant counters gnt_cnt0/gnt_cnt1.
interface mem_read_arbiter_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] rdata0;
  logic              rvalid0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] rdata1;
  logic              rvalid1;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_readE;
  logic [DATA_W-1:0] mem_data;
  logic              busy;
`ifdef MEMARB_STATS_EN
  logic [15:0]       gnt_cnt0;
  logic [15:0]       gnt_cnt1;
`endif

  modport master (
    input  req0, addr0, req1, addr1, mem_data,
    output rdata0, rvalid0, rdata1, rvalid1, mem_address, mem_readE, busy
`ifdef MEMARB_STATS_EN
    , output gnt_cnt0, gnt_cnt1
`endif
  );

  modport slave (
    output req0, addr0, req1, addr1, mem_data,
    input  rdata0, rvalid0, rdata1, rvalid1, mem_address, mem_readE, busy
`ifdef MEMARB_STATS_EN
    , input gnt_cnt0, gnt_cnt1
`endif
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
// Purpose : two-client round-robin read arbiter/sequencer for the bit8mem
//           read port. Grants one client, holds address + readE for
//           MEM_LAT+1 cycles, samples memory data and returns it with a
//           one-cycle valid pulse.
// Ports   :
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high reset
//   io_bus - mem_read_arbiter_if.master (client req/addr/rdata/rvalid x2,
//            mem_address, mem_readE, mem_data, busy)
// Optional: `define MEMARB_STATS_EN to add saturating grant counters
//           gnt_cnt0/gnt_cnt1 on the interface.
//
// state   | meaning
// S_IDLE  | arbitrate; latch granted address
// S_ISSUE | readE high, load latency counter
// S_WAIT  | readE high, count down remaining latency
// S_RESP  | sample mem_data into granted client, pulse its rvalid
module mem_read_arbiter #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_read_arbiter_if.master  io_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LP_LAT = 4'(MEM_LAT);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_gnt_id;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic              w_grant;
  logic              w_gnt_id;
  logic              w_readE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_grant  = 1'b0;
    w_gnt_id = 1'b0;
    w_readE  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.req0 || io_bus.req1) begin
          w_grant = 1'b1;
          // On a tie the client that was not served last wins.
          if (io_bus.req0 && io_bus.req1) w_gnt_id = ~r_last;
          else                            w_gnt_id = io_bus.req1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_readE = 1'b1;
        w_next  = (LP_LAT == 4'd0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        w_readE = 1'b1;
        if (r_cnt <= 4'd1) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= 4'd0;
      r_gnt_id  <= 1'b0;
      r_last    <= 1'b1;
      r_addr    <= '0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      if (w_grant) begin
        r_addr   <= w_gnt_id ? io_bus.addr1 : io_bus.addr0;
        r_gnt_id <= w_gnt_id;
        r_last   <= w_gnt_id;
      end
      if (r_state == S_ISSUE)     r_cnt <= LP_LAT;
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
      if (r_state == S_RESP) begin
        if (r_gnt_id) begin
          r_rdata1  <= io_bus.mem_data;
          r_rvalid1 <= 1'b1;
        end else begin
          r_rdata0  <= io_bus.mem_data;
          r_rvalid0 <= 1'b1;
        end
      end
    end
  end

`ifdef MEMARB_STATS_EN
  logic [15:0] r_gnt_cnt0;
  logic [15:0] r_gnt_cnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt_cnt0 <= 16'd0;
      r_gnt_cnt1 <= 16'd0;
    end else if (w_grant) begin
      if (w_gnt_id) begin
        if (r_gnt_cnt1 != 16'hFFFF) r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
      end else begin
        if (r_gnt_cnt0 != 16'hFFFF) r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
      end
    end
  end

  assign io_bus.gnt_cnt0 = r_gnt_cnt0;
  assign io_bus.gnt_cnt1 = r_gnt_cnt1;
`endif

  // mem_address simply holds the last granted address; readE alone gates the memory.
  assign io_bus.mem_address = r_addr;
  assign io_bus.mem_readE   = w_readE;
  assign io_bus.busy        = (r_state != S_IDLE);
  assign io_bus.rdata0      = r_rdata0;
  assign io_bus.rdata1      = r_rdata1;
  assign io_bus.rvalid0     = r_rvalid0;
  assign io_bus.rvalid1     = r_rvalid1;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter
// Purpose : scoreboard bench for mem_read_arbiter. The stimulus side predicts
//           grant order from the round-robin rule and pushes the expected
//           (client, address, data) of every read; a monitor pops and compares
//           on every rvalid pulse, also checking readE/busy cycle counts.
module tb_mem_read_arbiter;
  localparam int ADDR_W  = 27;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 3;

  typedef struct {
    logic              id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];
  logic m_last;
  int   m_gnt0;
  int   m_gnt1;

  mem_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  // Memory contents: a fixed scramble of the address.
  function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    return ({5'b0, a} * 32'h9E3779B1) ^ {a[10:0], a[26:6]} ^ 32'hC3A5_0F1E;
  endfunction

  assign bus.mem_data = mem_f(bus.mem_address);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Model of one grant: who is served and what it must receive.
  task automatic push(input logic id, input logic [ADDR_W-1:0] a);
    exp_t e;
    e.id = id; e.addr = a; e.data = mem_f(a);
    exp_q.push_back(e);
    m_last = id;
    if (id) m_gnt1++; else m_gnt0++;
  endtask

  task automatic set_req(input logic c, input logic v);
    if (c) bus.req1 = v; else bus.req0 = v;
  endtask

  task automatic set_addr(input logic c, input logic [ADDR_W-1:0] a);
    if (c) bus.addr1 = a; else bus.addr0 = a;
  endtask

  task automatic wait_rvalid(input logic c);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (c ? bus.rvalid1 : bus.rvalid0) seen = 1'b1;
    end
    chk(c ? "rvalid1_timeout" : "rvalid0_timeout", seen, 1'b1);
  endtask

  // mode 0: plain read; 1: drop req and change addr during WAIT;
  // 2: keep req high through the IDLE after the response (second read).
  task automatic single(input logic c, input logic [ADDR_W-1:0] a,
                        input int mode, input logic [ADDR_W-1:0] a_new);
    @(negedge clk);
    set_addr(c, a);
    set_req(c, 1'b1);
    push(c, a);
    if (mode == 1) begin
      repeat (2) @(negedge clk);
      set_addr(c, a_new);
      set_req(c, 1'b0);
      wait_rvalid(c);
    end else if (mode == 2) begin
      push(c, a);
      wait_rvalid(c);
      @(negedge clk);
      set_req(c, 1'b0);
      wait_rvalid(c);
    end else begin
      wait_rvalid(c);
      set_req(c, 1'b0);
    end
  endtask

  // Both clients request together; holds=2 keeps both high for 4 reads.
  task automatic both(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                      input int holds);
    logic w;
    logic [ADDR_W-1:0] aw, al;
    w  = ~m_last;
    aw = w ? a1 : a0;
    al = w ? a0 : a1;
    @(negedge clk);
    bus.addr0 = a0; bus.addr1 = a1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 0; k < holds; k++) begin
      push(w, aw);
      push(~w, al);
    end
    for (int k = 0; k < holds; k++) begin
      wait_rvalid(w);
      if (k == holds - 1) set_req(w, 1'b0);
      wait_rvalid(~w);
      if (k == holds - 1) set_req(~w, 1'b0);
    end
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return '0;
    if (sel == 1) return '1;
    return ADDR_W'($urandom);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_readE"},  bus.mem_readE, 1'b0);
    chk({tag, "_busy"},   bus.busy, 1'b0);
    chk({tag, "_rvalid0"}, bus.rvalid0, 1'b0);
    chk({tag, "_rvalid1"}, bus.rvalid1, 1'b0);
    chk({tag, "_rdata0"}, bus.rdata0, 32'd0);
    chk({tag, "_rdata1"}, bus.rdata1, 32'd0);
    chk({tag, "_addr"},   bus.mem_address, 27'd0);
`ifdef MEMARB_STATS_EN
    chk({tag, "_gnt_cnt0"}, bus.gnt_cnt0, 16'd0);
    chk({tag, "_gnt_cnt1"}, bus.gnt_cnt1, 16'd0);
`endif
  endtask

  // Monitor: compares each response against the head of the scoreboard.
  initial begin
    int rd_cnt;
    int busy_cnt;
    logic [DATA_W-1:0] held0;
    logic [DATA_W-1:0] held1;
    exp_t e;
    logic id;
    rd_cnt = 0; busy_cnt = 0; held0 = '0; held1 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        rd_cnt = 0; busy_cnt = 0; held0 = '0; held1 = '0;
      end else begin
        if (bus.mem_readE) rd_cnt++;
        if (bus.busy) busy_cnt++;
        chk("readE_in_idle", bus.mem_readE & ~bus.busy, 1'b0);
        if (bus.rvalid0 || bus.rvalid1) begin
          chk("rvalid_exclusive", bus.rvalid0 & bus.rvalid1, 1'b0);
          id = bus.rvalid1;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rvalid actual=client%0d required=none", id);
          end else begin
            e = exp_q.pop_front();
            chk("grant_order", id, e.id);
            chk("rdata", id ? bus.rdata1 : bus.rdata0, e.data);
            chk("mem_address", bus.mem_address, e.addr);
            chk("other_rdata_held", id ? bus.rdata0 : bus.rdata1, id ? held0 : held1);
            chk("readE_cycles", rd_cnt, MEM_LAT + 1);
            chk("busy_cycles", busy_cnt, MEM_LAT + 2);
            if (id) held1 = e.data; else held0 = e.data;
          end
          rd_cnt = 0; busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    n_checks = 0; n_fail = 0;
    m_last = 1'b1; m_gnt0 = 0; m_gnt1 = 0;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    reset = 1'b0;

    single(1'b0, 27'd9, 0, '0);
    both(27'd5, 27'd6, 2);
    single(1'b1, '1, 0, '0);
    single(1'b0, '0, 0, '0);
    single(1'b0, 27'd9, 1, 27'd20);
    single(1'b1, 27'd77, 2, '0);

    for (int n = 0; n < 250; n++) begin
      int pat;
      pat = $urandom_range(0, 3);
      if (pat < 2) single(pat[0], rand_addr(), $urandom_range(0, 2), rand_addr());
      else         both(rand_addr(), rand_addr(), pat - 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset while in WAIT: an in-flight read is abandoned silently.
    repeat (4) @(negedge clk);
    bus.addr0 = 27'd123;
    bus.req0 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus.req0 = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    m_last = 1'b1; m_gnt0 = 0; m_gnt1 = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    both(27'd40, 27'd41, 1);

    for (int a = 0; a < 200; a++) single(1'b1, ADDR_W'(a), 0, '0);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
`ifdef MEMARB_STATS_EN
    chk("gnt_cnt0", bus.gnt_cnt0, 16'(m_gnt0));
    chk("gnt_cnt1", bus.gnt_cnt1, 16'(m_gnt1));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
